paula_audio_mixer_new: RTL and testbench

- Stage directly downstream of the four paula_audio_channel_new instances.
- Scales each channel's 8-bit two's-complement sample by its 7-bit volume, using a single time-multiplexed multiplier.
- Sums channels into Amiga stereo pairs: left = ch0+ch3, right = ch1+ch2.
- Presents registered 16-bit signed left/right words plus a one-cycle update strobe to the downstream audio filter/DAC path.

---
 rtl/paula_audio_mixer_new.sv | 165 ++++++++++++++++
 tb/tb_paula_audio_mixer_new.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paula_audio_mixer_new.sv
// Paula audio mixer: scales four channel samples by their volumes with one
// shared multiplier and sums them into Amiga stereo pairs
// (left = ch0 + ch3, right = ch1 + ch2).
// A new mix is published once every five 7 MHz enables.
module paula_audio_mixer_new #(
    parameter bit MIX_SWAP = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk7_en,
    input  logic [7:0]         sample0,
    input  logic [7:0]         sample1,
    input  logic [7:0]         sample2,
    input  logic [7:0]         sample3,
    input  logic [6:0]         vol0,
    input  logic [6:0]         vol1,
    input  logic [6:0]         vol2,
    input  logic [6:0]         vol3,
    input  logic [3:0]         chmask,
    output logic signed [15:0] left,
    output logic signed [15:0] right,
    output logic               out_stb
);

    typedef enum logic [2:0] {
        SLOT0 = 3'd0,
        SLOT1 = 3'd1,
        SLOT2 = 3'd2,
        SLOT3 = 3'd3,
        SLOT4 = 3'd4
    } SlotState;

    SlotState         slot_q, slot_d;
    logic [3:0][7:0]  sampSnap_q;
    logic [3:0][6:0]  volSnap_q;
    logic [3:0]       maskSnap_q;
    logic [15:0]      accL_q, accL_d;
    logic [15:0]      accR_q, accR_d;
    logic [15:0]      left_q, right_q;
    logic             outStb_q, outStb_d;

    logic [7:0]       selSamp;
    logic [6:0]       selVol;
    logic             selMask;
    logic [6:0]       effVol;
    logic [15:0]      sampExt, volExt, prod;

    // Slot sequencer: 0 publishes and snapshots, 1..4 each handle one channel.
    always_comb begin
        slot_d = SLOT0;
        case (slot_q)
            SLOT0:   slot_d = SLOT1;
            SLOT1:   slot_d = SLOT2;
            SLOT2:   slot_d = SLOT3;
            SLOT3:   slot_d = SLOT4;
            SLOT4:   slot_d = SLOT0;
            default: slot_d = SLOT0;
        endcase
    end

    // Route the snapshot of the channel owned by this slot into the shared multiplier.
    always_comb begin
        selSamp = 8'd0;
        selVol  = 7'd0;
        selMask = 1'b0;
        case (slot_q)
            SLOT1: begin
                selSamp = sampSnap_q[0];
                selVol  = volSnap_q[0];
                selMask = maskSnap_q[0];
            end
            SLOT2: begin
                selSamp = sampSnap_q[1];
                selVol  = volSnap_q[1];
                selMask = maskSnap_q[1];
            end
            SLOT3: begin
                selSamp = sampSnap_q[2];
                selVol  = volSnap_q[2];
                selMask = maskSnap_q[2];
            end
            SLOT4: begin
                selSamp = sampSnap_q[3];
                selVol  = volSnap_q[3];
                selMask = maskSnap_q[3];
            end
            default: begin
                selSamp = 8'd0;
                selVol  = 7'd0;
                selMask = 1'b0;
            end
        endcase
    end

    // Volume bit 6 means full scale (64) regardless of the low bits; the 16-bit
    // truncated product of sign-extended operands is the exact signed result.
    always_comb begin
        effVol  = selVol[6] ? 7'd64 : {1'b0, selVol[5:0]};
        sampExt = {{8{selSamp[7]}}, selSamp};
        volExt  = {9'd0, effVol};
        prod    = selMask ? (sampExt * volExt) : 16'd0;
    end

    // First channel of each pair loads its accumulator, the second adds to it.
    always_comb begin
        accL_d = accL_q;
        accR_d = accR_q;
        case (slot_q)
            SLOT1:   accL_d = prod;
            SLOT2:   accR_d = prod;
            SLOT3:   accR_d = accR_q + prod;
            SLOT4:   accL_d = accL_q + prod;
            default: begin
                accL_d = accL_q;
                accR_d = accR_q;
            end
        endcase
    end

    // Strobe accompanies the publishing enable edge and is cleared on the next clk.
    always_comb begin
        outStb_d = clk7_en && (slot_q == SLOT0);
    end

    // Enable-gated state: sequencer, snapshots, accumulators and published outputs.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                slot_q     <= SLOT0;
                sampSnap_q <= '0;
                volSnap_q  <= '0;
                maskSnap_q <= '0;
                accL_q     <= '0;
                accR_q     <= '0;
                left_q     <= '0;
                right_q    <= '0;
            end else begin
                slot_q <= slot_d;
                accL_q <= accL_d;
                accR_q <= accR_d;
                if (slot_q == SLOT0) begin
                    sampSnap_q <= {sample3, sample2, sample1, sample0};
                    volSnap_q  <= {vol3, vol2, vol1, vol0};
                    maskSnap_q <= chmask;
                    left_q     <= MIX_SWAP ? accR_q : accL_q;
                    right_q    <= MIX_SWAP ? accL_q : accR_q;
                end
            end
        end
    end

    // Strobe register runs on every clk so the pulse is exactly one clk wide.
    always_ff @(posedge clk) begin
        if (reset) begin
            outStb_q <= 1'b0;
        end else begin
            outStb_q <= outStb_d;
        end
    end

    assign left    = left_q;
    assign right   = right_q;
    assign out_stb = outStb_q;

endmodule

// File: tb/tb_paula_audio_mixer_new.sv
// Bench for paula_audio_mixer_new: a mix-level reference model checked every
// cycle against two instances (normal and swapped), plus literal checks.
module tb_paula_audio_mixer_new;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clk7_en;
    logic [7:0]  samp [4];
    logic [6:0]  vol [4];
    logic [3:0]  chmask;
    logic signed [15:0] left, right, leftSw, rightSw;
    logic        outStb, outStbSw;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;
    int cycCnt   = 0;

    // Reference model state
    int          phase = 0;
    logic [7:0]  mSamp [4];
    logic [6:0]  mVol [4];
    logic [3:0]  mMask;
    logic [15:0] expL, expR;
    logic        expStb;

    paula_audio_mixer_new #(.MIX_SWAP(1'b0)) dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en),
        .sample0(samp[0]), .sample1(samp[1]), .sample2(samp[2]), .sample3(samp[3]),
        .vol0(vol[0]), .vol1(vol[1]), .vol2(vol[2]), .vol3(vol[3]),
        .chmask(chmask), .left(left), .right(right), .out_stb(outStb)
    );

    paula_audio_mixer_new #(.MIX_SWAP(1'b1)) dutSwap (
        .clk(clk), .reset(reset), .clk7_en(clk7_en),
        .sample0(samp[0]), .sample1(samp[1]), .sample2(samp[2]), .sample3(samp[3]),
        .vol0(vol[0]), .vol1(vol[1]), .vol2(vol[2]), .vol3(vol[3]),
        .chmask(chmask), .left(leftSw), .right(rightSw), .out_stb(outStbSw)
    );

    // Scaled contribution of one channel
    function automatic int chanProd(input logic [7:0] s, input logic [6:0] v, input logic m);
        int effVol;
        effVol = v[6] ? 64 : int'(v[5:0]);
        if (!m) return 0;
        return int'($signed(s)) * effVol;
    endfunction

    function automatic logic [15:0] mixPair(input int a, input int b);
        int s;
        s = a + b;
        return s[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%04h required=0x%04h", name, act, exp);
        end
    endtask

    // Model: every fifth enable publishes the mix of the previous snapshot
    always @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                phase  <= 0;
                expL   <= 16'd0;
                expR   <= 16'd0;
                expStb <= 1'b0;
                mMask  <= 4'd0;
                for (int i = 0; i < 4; i++) begin
                    mSamp[i] <= 8'd0;
                    mVol[i]  <= 7'd0;
                end
            end else begin
                expStb <= (phase == 0);
                if (phase == 0) begin
                    expL <= mixPair(chanProd(mSamp[0], mVol[0], mMask[0]),
                                    chanProd(mSamp[3], mVol[3], mMask[3]));
                    expR <= mixPair(chanProd(mSamp[1], mVol[1], mMask[1]),
                                    chanProd(mSamp[2], mVol[2], mMask[2]));
                    mMask <= chmask;
                    for (int i = 0; i < 4; i++) begin
                        mSamp[i] <= samp[i];
                        mVol[i]  <= vol[i];
                    end
                end
                phase <= (phase + 1) % 5;
            end
        end else begin
            expStb <= 1'b0;
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_left", left, expL);
            checkOutput("cyc_right", right, expR);
            checkOutput("cyc_stb", {15'd0, outStb}, {15'd0, expStb});
            checkOutput("cyc_swap_left", leftSw, expR);
            checkOutput("cyc_swap_right", rightSw, expL);
            checkOutput("cyc_swap_stb", {15'd0, outStbSw}, {15'd0, expStb});
        end
    end

    // Advance to the next negedge, report the strobe seen, drive the next enable
    task automatic stepCycle(input int div, output logic stbSeen);
        @(negedge clk);
        stbSeen = outStb;
        clk7_en = ((cycCnt % div) == 0);
        cycCnt++;
    endtask

    task automatic waitStrobes(input int k, input int div);
        int   seen;
        int   n;
        logic s;
        seen = 0;
        n    = 0;
        while (seen < k && n < 500) begin
            stepCycle(div, s);
            if (s) seen++;
            n++;
        end
        if (seen < k) begin
            checks++;
            failures++;
            $display("[TB] FAIL strobe_timeout actual=%0d required=%0d", seen, k);
        end
    endtask

    // Samples packed {ch3,ch2,ch1,ch0}, volumes likewise
    task automatic applyStimulus(input logic [31:0] sPk, input logic [27:0] vPk, input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            samp[i] = sPk[i*8 +: 8];
            vol[i]  = vPk[i*7 +: 7];
        end
        chmask = m;
    endtask

    task automatic applyReset();
        reset   = 1'b1;
        clk7_en = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
    endtask

    logic [6:0]  t3Vol [3] = '{7'h7F, 7'h40, 7'h20};
    logic [15:0] t3Exp [3] = '{16'h1000, 16'h1000, 16'h0800};

    initial begin
        logic s;
        logic prev;
        int   width;
        int   lastRise;
        int   nGaps;

        applyStimulus(32'd0, 28'd0, 4'h0);
        applyReset();
        checkEn = 1'b1;
        checkOutput("reset_left", left, 16'h0000);
        checkOutput("reset_right", right, 16'h0000);
        checkOutput("reset_stb", {15'd0, outStb}, 16'h0000);

        // Single full-scale positive channel on the left
        applyStimulus({8'h00, 8'h00, 8'h00, 8'h7F}, {7'h00, 7'h00, 7'h00, 7'h40}, 4'hF);
        waitStrobes(1, 1);
        checkOutput("t1_first_strobe_left", left, 16'h0000);
        waitStrobes(1, 1);
        checkOutput("t1_left", left, 16'h1FC0);
        checkOutput("t1_right", right, 16'h0000);
        checkOutput("t1_model_left", expL, 16'h1FC0);
        checkOutput("t1_swap_left", leftSw, 16'h0000);
        checkOutput("t1_swap_right", rightSw, 16'h1FC0);

        // Negative extreme on the right pair
        applyStimulus({8'h00, 8'h80, 8'h80, 8'h00}, {7'h00, 7'h40, 7'h40, 7'h00}, 4'hF);
        waitStrobes(2, 1);
        checkOutput("t2_right", right, 16'hC000);
        checkOutput("t2_left", left, 16'h0000);
        checkOutput("t2_model_right", expR, 16'hC000);

        // Volume bit 6 clamps to 64
        for (int i = 0; i < 3; i++) begin
            applyStimulus({8'h40, 24'h0}, {t3Vol[i], 21'h0}, 4'hF);
            waitStrobes(2, 1);
            checkOutput($sformatf("t3_left_vol%02h", t3Vol[i]), left, t3Exp[i]);
        end

        // Channel masking, with and without swap
        applyStimulus({4{8'h10}}, {4{7'h10}}, 4'b1010);
        waitStrobes(2, 1);
        checkOutput("t4_left", left, 16'h0100);
        checkOutput("t4_right", right, 16'h0100);
        checkOutput("t4_swap_left", leftSw, 16'h0100);
        checkOutput("t4_swap_right", rightSw, 16'h0100);
        applyStimulus({4{8'h10}}, {4{7'h10}}, 4'b1000);
        waitStrobes(2, 1);
        checkOutput("t4m_left", left, 16'h0100);
        checkOutput("t4m_right", right, 16'h0000);
        checkOutput("t4m_swap_left", leftSw, 16'h0000);
        checkOutput("t4m_swap_right", rightSw, 16'h0100);
        checkOutput("t4m_model_left", expL, 16'h0100);

        // Sparse enables: one-clk strobe every 20 clks
        applyStimulus({8'h00, 8'h00, 8'h10, 8'h7F}, {7'h00, 7'h00, 7'h10, 7'h40}, 4'hF);
        prev     = 1'b0;
        width    = 0;
        lastRise = -1;
        nGaps    = 0;
        for (int i = 0; i < 300 && nGaps < 4; i++) begin
            stepCycle(4, s);
            if (s) width++;
            if (s && !prev) begin
                if (lastRise >= 0) begin
                    checkOutput("t5_gap", 16'(i - lastRise), 16'd20);
                    nGaps++;
                end
                lastRise = i;
            end
            if (!s && prev) begin
                checkOutput("t5_width", 16'(width), 16'd1);
                width = 0;
            end
            prev = s;
        end
        checkOutput("t5_enough_gaps", {15'd0, nGaps >= 4}, 16'd1);
        checkOutput("t5_left", left, 16'h1FC0);
        checkOutput("t5_right", right, 16'h0100);

        // Reset in the middle of accumulation (slot 3)
        waitStrobes(1, 1);
        stepCycle(1, s);
        stepCycle(1, s);
        checkOutput("t6_pre_left", left, 16'h1FC0);
        applyReset();
        checkOutput("t6_rst_left", left, 16'h0000);
        checkOutput("t6_rst_right", right, 16'h0000);
        checkOutput("t6_rst_stb", {15'd0, outStb}, 16'h0000);
        waitStrobes(1, 1);
        checkOutput("t6_first_left", left, 16'h0000);
        checkOutput("t6_first_right", right, 16'h0000);
        waitStrobes(1, 1);
        checkOutput("t6_second_left", left, 16'h1FC0);
        checkOutput("t6_second_right", right, 16'h0100);

        @(negedge clk);
        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
